// File: rtl/vec_reg_file_p.sv
// vec_reg_file_p -- parametrised vector register file for the vector ASIP datapath.
//
// Each register holds LANES lanes of LANE_W bits (W = LANES*LANE_W); lane i sits at
// bits [i*LANE_W +: LANE_W]. One masked write port, one full-width preload port
// (valid/ready, lower priority than the write port), two combinational read ports
// with optional same-cycle write forwarding, and a per-register pending-write
// scoreboard for decode hazard checks. A clear sequencer zeroes one register per
// cycle after reset or on clr_start; while it runs every update is dropped.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   clr_start / clr_busy   start a clear walk / walk in progress
//   we, wa, wmask, wd      masked write port
//   ld_valid, ld_ready,
//   ld_addr, ld_data       preload port, accepted when ld_valid & ld_ready
//   ra1, ra2 / rd1, rd2    read addresses / read data (0-cycle latency)
//   rsv_valid, rsv_addr    mark a register as pending a write
//   pend1, pend2           pending bit of ra1 / ra2 (registered state only)
//   err_drop               sticky: write or reservation dropped during a clear
module vec_reg_file_p #(
  parameter int NUM_REGS = 16,
  parameter int LANES    = 6,
  parameter int LANE_W   = 8,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int BYPASS   = 1,
  localparam int W       = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_start,
  output logic              clr_busy,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [LANES-1:0]  wmask,
  input  logic [W-1:0]      wd,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [AW-1:0]     ld_addr,
  input  logic [W-1:0]      ld_data,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [W-1:0]      rd1,
  output logic [W-1:0]      rd2,
  input  logic              rsv_valid,
  input  logic [AW-1:0]     rsv_addr,
  output logic              pend1,
  output logic              pend2,
  output logic              err_drop
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  // When NUM_REGS fills the address space every address is valid and the range
  // compare folds away.
  localparam bit            FULL_DECODE = (NUM_REGS == (1 << AW));
  localparam logic [AW-1:0] LAST_REG    = AW'(NUM_REGS - 1);

  state_t                state;
  logic [AW-1:0]         count;
  logic [W-1:0]          rf [NUM_REGS];
  logic [NUM_REGS-1:0]   pend;
  logic [NUM_REGS-1:0]   pend_nxt;
  logic                  ld_acc;

  function automatic logic in_range(input logic [AW-1:0] a);
    return FULL_DECODE || (int'(a) < NUM_REGS);
  endfunction

  // Sequencer: CLEAR visits every register once, then falls back to IDLE.
  // clr_start is only honoured from IDLE, so a running walk never restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every block sees
    // the pre-edge values regardless of evaluation order.
    if (!rst_n) begin
      state    <= S_CLEAR;
      count    <= '0;
      err_drop <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (we || rsv_valid) err_drop <= 1'b1;
          if (count == LAST_REG) state <= S_IDLE;
          count <= count + 1'b1;
        end
        default: begin
          if (clr_start) begin
            state <= S_CLEAR;
            count <= '0;
          end
        end
      endcase
    end
  end

  assign clr_busy = (state == S_CLEAR);
  // The write port has priority: a preload waits out any cycle with we=1.
  assign ld_ready = (state == S_IDLE) && !we;
  assign ld_acc   = ld_valid && ld_ready;

  // Storage array. The clear walk, not the reset, brings it to a known value.
  // NOTE: the array has no reset branch; resetting a memory turns it into a
  // flop bank with a reset fan-out instead of a RAM-style structure.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      rf[count] <= '0;
    end else if (we) begin
      if (in_range(wa)) begin
        for (int i = 0; i < LANES; i++) begin
          if (wmask[i]) rf[wa][i*LANE_W +: LANE_W] <= wd[i*LANE_W +: LANE_W];
        end
      end
    end else if (ld_acc && in_range(ld_addr)) begin
      rf[ld_addr] <= ld_data;
    end
  end

  // Scoreboard next state. The reservation is applied last so that a set and
  // a clear on the same register in the same cycle leave it pending.
  always_comb begin
    // NOTE: default first, so no path through this block leaves pend_nxt
    // unassigned and no latch is inferred.
    pend_nxt = pend;
    if (state == S_IDLE) begin
      if (clr_start) begin
        pend_nxt = '0;
      end else begin
        if (we && in_range(wa))           pend_nxt[wa]       = 1'b0;
        if (ld_acc && in_range(ld_addr))  pend_nxt[ld_addr]  = 1'b0;
        if (rsv_valid && in_range(rsv_addr)) pend_nxt[rsv_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;
  end

  // Read port: zero while clearing or for an unmapped address; otherwise the
  // stored value with any lanes being written this cycle forwarded from wd.
  // The preload port is deliberately not forwarded.
  function automatic logic [W-1:0] read_port(input logic [AW-1:0] a);
    logic [W-1:0] v;
    v = '0;
    if (state == S_IDLE && in_range(a)) begin
      v = rf[a];
      if (BYPASS != 0 && we && wa == a) begin
        for (int i = 0; i < LANES; i++) begin
          if (wmask[i]) v[i*LANE_W +: LANE_W] = wd[i*LANE_W +: LANE_W];
        end
      end
    end
    return v;
  endfunction

  function automatic logic pend_port(input logic [AW-1:0] a);
    return (state == S_IDLE) && in_range(a) && pend[a];
  endfunction

  always_comb rd1   = read_port(ra1);
  always_comb rd2   = read_port(ra2);
  always_comb pend1 = pend_port(ra1);
  always_comb pend2 = pend_port(ra2);

endmodule

// File: tb/tb_vec_reg_file_p.sv
// tb_vec_reg_file_p -- directed bench for vec_reg_file_p (default parameters).
// Stimulus drives inputs just after each rising edge and pushes the values the
// outputs must show during that cycle into a queue; a monitor on the falling
// edge pops every entry due in the current cycle and compares it.
module tb_vec_reg_file_p;

  localparam int AW = 4;
  localparam int W  = 48;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_start;
  logic          clr_busy;
  logic          we;
  logic [AW-1:0] wa;
  logic [5:0]    wmask;
  logic [W-1:0]  wd;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;
  logic [AW-1:0] ra1, ra2;
  logic [W-1:0]  rd1, rd2;
  logic          rsv_valid;
  logic [AW-1:0] rsv_addr;
  logic          pend1, pend2;
  logic          err_drop;

  vec_reg_file_p dut (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .clr_busy(clr_busy),
    .we(we), .wa(wa), .wmask(wmask), .wd(wd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .pend1(pend1), .pend2(pend2), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  typedef enum int {O_RD1, O_RD2, O_BUSY, O_LDRDY, O_PEND1, O_PEND2, O_ERR} obs_t;

  typedef struct {
    int          cyc;
    obs_t        sel;
    logic [W-1:0] exp_v;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic void expect_val(obs_t sel, logic [W-1:0] v, string name);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.exp_v = v; e.name = name;
    sb.push_back(e);
  endfunction

  function automatic logic [W-1:0] observe(obs_t sel);
    case (sel)
      O_RD1:   return rd1;
      O_RD2:   return rd2;
      O_BUSY:  return W'(clr_busy);
      O_LDRDY: return W'(ld_ready);
      O_PEND1: return W'(pend1);
      O_PEND2: return W'(pend2);
      default: return W'(err_drop);
    endcase
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
  endtask

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, observe(e.sel), e.exp_v);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    clr_start = 0; we = 0; wa = '0; wmask = '0; wd = '0;
    ld_valid = 0; ld_addr = '0; ld_data = '0; rsv_valid = 0; rsv_addr = '0;
  endtask

  // Release reset now and expect exactly 16 cycles of clr_busy.
  task automatic release_and_walk();
    rst_n = 1;
    expect_val(O_BUSY, 1, "busy_first");
    expect_val(O_LDRDY, 0, "ldrdy_in_clear");
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k < 16) expect_val(O_BUSY, 1, "busy_walk");
      else begin
        expect_val(O_BUSY, 0, "busy_done");
        expect_val(O_LDRDY, 1, "ldrdy_after_clear");
        expect_val(O_ERR, 0, "err_after_clear");
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    quiet();
    ra1 = '0; ra2 = '0;
    rst_n = 0;
    repeat (3) step();
    expect_val(O_BUSY, 1, "rst_busy");
    expect_val(O_LDRDY, 0, "rst_ldrdy");
    expect_val(O_RD1, 0, "rst_rd1");
    expect_val(O_PEND1, 0, "rst_pend1");
    expect_val(O_ERR, 0, "rst_err");
    step();
    release_and_walk();

    // Every register reads zero after the walk.
    for (int i = 0; i < 16; i++) begin
      step();
      ra1 = AW'(i); ra2 = AW'(15 - i);
      expect_val(O_RD1, 0, "clr_rd1");
      expect_val(O_RD2, 0, "clr_rd2");
      expect_val(O_PEND1, 0, "clr_pend1");
    end

    // Full-mask write, forwarded in the same cycle and stored afterwards.
    step();
    we = 1; wa = 4; wmask = 6'b111111; wd = 48'd69540876599103; ra1 = 4;
    expect_val(O_RD1, 48'h3F3F3F3F3F3F, "wr_full_bypass");
    expect_val(O_LDRDY, 0, "ldrdy_we");
    step();
    quiet();
    expect_val(O_RD1, 48'h3F3F3F3F3F3F, "wr_full");
    step();
    we = 1; wa = 4; wmask = 6'b000001; wd = 48'hFF;
    expect_val(O_RD1, 48'h3F3F3F3F3FFF, "wr_lane0_bypass");
    step();
    quiet();
    expect_val(O_RD1, 48'h3F3F3F3F3FFF, "wr_lane0");

    // Partial forwarding: written lanes from wd, others from the array.
    step();
    we = 1; wa = 4; wmask = 6'b100000; wd = 48'h110000000000;
    expect_val(O_RD1, 48'h113F3F3F3FFF, "wr_lane5_bypass");
    step();
    we = 1; wa = 6; wmask = 6'b000011; wd = 48'h00000000ABCD; ra2 = 6;
    expect_val(O_RD2, 48'h00000000ABCD, "bypass_r6");
    expect_val(O_RD1, 48'h113F3F3F3FFF, "wr_lane5");
    step();
    quiet();
    expect_val(O_RD2, 48'h00000000ABCD, "r6_stored");

    // Preload held off by the write port, then accepted; not forwarded.
    step();
    ld_valid = 1; ld_addr = 10; ld_data = 48'd25; ra1 = 10;
    we = 1; wa = 0; wmask = 6'b000000; wd = 48'hFFFF;
    expect_val(O_LDRDY, 0, "ld_blocked");
    expect_val(O_RD1, 0, "ld_r10_before");
    step();
    we = 0;
    expect_val(O_LDRDY, 1, "ld_accept");
    expect_val(O_RD1, 0, "ld_not_bypassed");
    step();
    quiet();
    expect_val(O_RD1, 48'd25, "ld_r10");

    // Scoreboard: set, set-beats-clear, clear.
    step();
    rsv_valid = 1; rsv_addr = 11; ra1 = 11;
    expect_val(O_PEND1, 0, "pend_not_bypassed");
    step();
    we = 1; wa = 11; wmask = 6'b111111; wd = 48'd7;
    expect_val(O_PEND1, 1, "pend_set");
    step();
    rsv_valid = 0;
    expect_val(O_PEND1, 1, "pend_set_wins");
    step();
    quiet();
    expect_val(O_PEND1, 0, "pend_cleared_by_we");
    expect_val(O_RD1, 48'd7, "r11_data");

    // A preload also clears pending.
    step();
    rsv_valid = 1; rsv_addr = 12; ra2 = 12;
    step();
    quiet();
    ld_valid = 1; ld_addr = 12; ld_data = 48'd9;
    expect_val(O_PEND2, 1, "pend12_set");
    step();
    quiet();
    expect_val(O_PEND2, 0, "pend12_cleared_by_ld");
    expect_val(O_RD2, 48'd9, "r12_data");

    // Clear interaction: reserve r13, clr_start at T, we at T+3, reset at T+5.
    step();
    rsv_valid = 1; rsv_addr = 13; ra2 = 13; ra1 = 4;
    step();
    quiet();
    clr_start = 1;                            // sampled at edge T
    expect_val(O_PEND2, 1, "pend13_set");
    expect_val(O_RD1, 48'h113F3F3F3FFF, "r4_before_clear");
    step();
    clr_start = 0;
    expect_val(O_BUSY, 1, "clr_busy_T1");
    expect_val(O_PEND2, 0, "pend_cleared_by_clr");
    expect_val(O_RD1, 0, "rd_zero_in_clear");
    step();
    clr_start = 1;                            // ignored while clearing
    expect_val(O_ERR, 0, "err_T2");
    step();
    clr_start = 0;
    we = 1; wa = 4; wmask = 6'b111111; wd = 48'hAAAAAAAAAAAA;  // sampled at T+3
    expect_val(O_ERR, 0, "err_T3");
    expect_val(O_LDRDY, 0, "ldrdy_clear_T3");
    step();
    quiet();
    expect_val(O_ERR, 1, "err_T4");
    step();
    rst_n = 0;                                // reset at T+5
    expect_val(O_ERR, 0, "err_reset");
    expect_val(O_BUSY, 1, "busy_reset");
    step();
    release_and_walk();
    step();
    ra1 = 4; ra2 = 13;
    expect_val(O_RD1, 0, "r4_cleared");
    expect_val(O_PEND2, 0, "pend13_after_reset");
    expect_val(O_RD2, 0, "r13_cleared");

    step();
    step();
    if (sb.size() != 0) check("scoreboard_drain", W'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vec_reg_file_p.md
Name: vec_reg_file_p

Overview:
- Parametrised vector register file for the vector ASIP datapath; successor to the fixed 14x48-bit file.
- Registers are LANES lanes of LANE_W bits, with a per-lane write mask, two combinational read ports and optional write-to-read bypass.
- A clear sequencer zeroes the array one register per cycle. A valid/ready preload port replaces PC-decoded constant initialisation.
- A pending-write scoreboard per register supports hazard detection in decode.

Parameters:
NUM_REGS, 16, number of vector registers
LANES, 6, lanes per register
LANE_W, 8, bits per lane; register width W = LANES*LANE_W (default 48)
AW, $clog2(NUM_REGS), register address width
BYPASS, 1, 1 = read ports forward same-cycle write data

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr_start  in  1  pulse: begin sequential clear of all registers
clr_busy  out  1  clear sequence in progress
we  in  1  write enable
wa  in  AW  write address
wmask  in  LANES  per-lane write enable
wd  in  W  write data
ld_valid  in  1  preload request
ld_ready  out  1  preload accepted when ld_valid & ld_ready
ld_addr  in  AW  preload address
ld_data  in  W  preload data (full register, all lanes)
ra1, ra2  in  AW  read addresses
rd1, rd2  out  W  read data
rsv_valid  in  1  reserve register (mark pending)
rsv_addr  in  AW  register to reserve
pend1, pend2  out  1  pending bit of ra1 / ra2
err_drop  out  1  sticky: a write or reservation was dropped during clear

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM enters CLEAR with count=0; all pend bits 0; err_drop=0.
  - Outputs during reset: clr_busy=1, ld_ready=0, rd1/rd2=0, pend1/pend2=0.
  - Array contents are not reset directly; the CLEAR walk zeroes them.
- FSM states IDLE and CLEAR.
  - CLEAR: each cycle writes 0 to rf[count] and increments count. When count==NUM_REGS-1, that register is written and the FSM goes to IDLE on the next edge, so CLEAR lasts exactly NUM_REGS cycles.
  - IDLE: clr_start=1 enters CLEAR with count=0 and clears all pend bits on the same edge.
  - clr_start while in CLEAR is ignored; the sequence does not restart.
  - rst_n asserted mid-clear restarts from count=0.
- clr_busy=1 exactly while in CLEAR.
- During CLEAR:
  - we, ld and rsv are dropped.
  - err_drop sets if we or rsv_valid is seen; ld is simply not accepted because ld_ready=0.
  - rd1/rd2 read 0; pend1/pend2 read 0.
  - err_drop is cleared only by reset.
- Write port, IDLE only:
  - On the edge, for each lane i with wmask[i]=1, rf[wa] lane i <= wd lane i. Unmasked lanes are unchanged.
  - we=1 with wmask=0 changes no data but still clears pend[wa].
- Preload port:
  - ld_ready = IDLE & ~we; the write port has priority.
  - On accept, rf[ld_addr] <= ld_data (all lanes) and pend[ld_addr] is cleared.
- Reads are combinational with 0-cycle latency: rdN = rf[raN].
  - With BYPASS=1 and we=1 with wa==raN, masked lanes come from wd and unmasked lanes from rf.
  - BYPASS does not cover the preload port.
- Scoreboard:
  - rsv_valid sets pend[rsv_addr] on the edge.
  - A write (we, or an accepted ld) clears pend at its address.
  - Same edge, same address for set and clear: set wins.
  - pendN = pend[raN], registered state only; it is not bypassed.
- Out-of-range addresses (>= NUM_REGS when NUM_REGS is not a power of 2):
  - Writes, loads and reservations are ignored.
  - Reads return 0 and pend reads 0.
- Width rules:
  - W = LANES*LANE_W; lane i occupies bits [i*LANE_W +: LANE_W].
  - No arithmetic is performed on data.

Test Plan:
- Reset, then release rst_n -> clr_busy=1 for exactly 16 cycles, then 0. All 16 registers read 0. ld_ready rises on the cycle clr_busy falls.
- IDLE: we=1, wa=4, wmask=6'b111111, wd=48'd69540876599103 -> next cycle rd1(ra1=4)=48'd69540876599103. Then we=1, wa=4, wmask=6'b000001, wd=48'hFF -> lane 0 =0xFF, lanes 1-5 unchanged.
- Bypass: with rf[6]=0, drive we=1, wa=6, wmask=6'b000011, wd=48'h00000000ABCD and ra2=6 in the same cycle -> rd2=48'h00000000ABCD combinationally. A BYPASS=0 build shows 0 that cycle.
- Preload arbitration: ld_valid=1 (ld_addr=10, ld_data=25) together with we=1 -> ld_ready=0 and the load is held. Next cycle with we=0 -> accepted; rf[10]=25.
- Scoreboard: rsv_valid, rsv_addr=11 -> pend1(ra1=11)=1 next cycle. Next, a write to r11 together with rsv_valid on r11 -> pend stays 1. Next, a write alone -> pend=0.
- Clear interaction: clr_start at time T, then we=1 at T+3 and reset asserted at T+5 -> err_drop=1 at T+4. After reset release the clear runs a full 16 cycles and err_drop=0.
